// File: rtl/rp_dac.sv
// rp_dac: interleaved DAC output stage.
// Takes signed channel-0/channel-1 sample pairs over a valid/ready handshake
// and converts them to DAC code format. It time-multiplexes both channels onto
// one DAC bus on alternate cycles and sequences the converter reset.
// A built-in ramp pattern can replace the input stream.
// All outputs are registered and are computed from the next-state values, so
// an output register always describes the state the block is entering.
module rp_dac #(
  parameter int DAC_BITWIDTH = 14,
  parameter int RST_CYCLES   = 16
) (
  input  logic                    adc_clk,
  input  logic                    adc_rstn,
  input  logic [DAC_BITWIDTH-1:0] dac0_in,
  input  logic [DAC_BITWIDTH-1:0] dac1_in,
  input  logic                    dac_valid,
  output logic                    dac_ready,
  input  logic                    enable,
  input  logic                    test_mode,
  output logic [DAC_BITWIDTH-1:0] dac_dat,
  output logic                    dac_sel,
  output logic                    dac_wrt,
  output logic                    dac_rst
);

  localparam int CNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [DAC_BITWIDTH-1:0] MID_SCALE = {1'b0, {(DAC_BITWIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_IDLE = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Two's complement sample -> offset-binary DAC code (inverted magnitude bits).
  function automatic logic [DAC_BITWIDTH-1:0] to_code(input logic [DAC_BITWIDTH-1:0] s);
    return {s[DAC_BITWIDTH-1], ~s[DAC_BITWIDTH-2:0]};
  endfunction

  // Control state.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  // Pair source for the pair currently on the bus: 1 = ramp, 0 = held pair.
  logic                    mode_q, mode_d;
  logic [DAC_BITWIDTH-1:0] hold0_q, hold0_d;
  logic [DAC_BITWIDTH-1:0] hold1_q, hold1_d;
  logic [DAC_BITWIDTH-1:0] ramp_q, ramp_d;

  // Output registers.
  logic [DAC_BITWIDTH-1:0] dat_q, dat_d;
  logic                    sel_q, sel_d;
  logic                    wrt_q, wrt_d;
  logic                    ready_q, ready_d;
  logic                    rst_q, rst_d;

  logic                    accept;
  logic [DAC_BITWIDTH-1:0] src0, src1;

  assign accept = ready_q & dac_valid;

  // Next-state logic: reset sequencing, phase toggling, pair capture and ramp.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    hold0_d = hold0_q;
    hold1_d = hold1_q;
    ramp_d  = ramp_q;

    unique case (state_q)
      ST_RST: begin
        phase_d = 1'b0;
        if (cnt_q == CNT_W'(RST_CYCLES)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        phase_d = 1'b0;
        if (enable) begin
          state_d = ST_RUN;
          mode_d  = test_mode;
        end
      end

      ST_RUN: begin
        // End of a pair: capture the next pair and advance the ramp.
        if (phase_q) begin
          if (accept) begin
            hold0_d = dac0_in;
            hold1_d = dac1_in;
          end
          if (mode_q) begin
            ramp_d = ramp_q + 1'b1;
          end
        end

        if (!enable) begin
          // Leaving RUN drops whatever pair was held, even one accepted this cycle.
          state_d = ST_IDLE;
          phase_d = 1'b0;
          hold0_d = '0;
          hold1_d = '0;
        end else begin
          phase_d = ~phase_q;
          // The source only changes at a pair boundary so a pair is never split.
          if (phase_q) begin
            mode_d = test_mode;
          end
        end
      end

      default: begin
        state_d = ST_RST;
        cnt_d   = '0;
        phase_d = 1'b0;
      end
    endcase
  end

  // Output decode from the next state, so the registers line up with the state they describe.
  always_comb begin
    src0    = mode_d ? ramp_d  : hold0_d;
    src1    = mode_d ? ~ramp_d : hold1_d;
    dat_d   = MID_SCALE;
    sel_d   = 1'b0;
    wrt_d   = 1'b0;
    ready_d = 1'b0;
    rst_d   = 1'b0;

    unique case (state_d)
      ST_RUN: begin
        dat_d   = phase_d ? to_code(src1) : to_code(src0);
        sel_d   = phase_d;
        wrt_d   = phase_d;
        ready_d = phase_d & ~mode_d & ~test_mode;
      end
      ST_IDLE: begin
        dat_d = MID_SCALE;
      end
      default: begin
        rst_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge adc_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!adc_rstn) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      mode_q  <= 1'b0;
      hold0_q <= '0;
      hold1_q <= '0;
      ramp_q  <= '0;
      dat_q   <= MID_SCALE;
      sel_q   <= 1'b0;
      wrt_q   <= 1'b0;
      ready_q <= 1'b0;
      rst_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      ramp_q  <= ramp_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      wrt_q   <= wrt_d;
      ready_q <= ready_d;
      rst_q   <= rst_d;
    end
  end

  assign dac_dat   = dat_q;
  assign dac_sel   = sel_q;
  assign dac_wrt   = wrt_q;
  assign dac_ready = ready_q;
  assign dac_rst   = rst_q;

endmodule

// File: tb/tb_rp_dac.sv
// Testbench for rp_dac: table-driven code vectors, hand-written corner
// sequences and a randomized run checked against a pair-level reference model.
module tb_rp_dac;

  localparam int W    = 14;
  localparam int RSTC = 16;

  logic         adc_clk = 1'b0;
  logic         adc_rstn;
  logic [W-1:0] dac0_in, dac1_in;
  logic         dac_valid, dac_ready;
  logic         enable, test_mode;
  logic [W-1:0] dac_dat;
  logic         dac_sel, dac_wrt, dac_rst;

  always #5 adc_clk = ~adc_clk;

  rp_dac #(.DAC_BITWIDTH(W), .RST_CYCLES(RSTC)) dut (
    .adc_clk   (adc_clk),
    .adc_rstn  (adc_rstn),
    .dac0_in   (dac0_in),
    .dac1_in   (dac1_in),
    .dac_valid (dac_valid),
    .dac_ready (dac_ready),
    .enable    (enable),
    .test_mode (test_mode),
    .dac_dat   (dac_dat),
    .dac_sel   (dac_sel),
    .dac_wrt   (dac_wrt),
    .dac_rst   (dac_rst)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = converter reset, 1 = idle, 2 = streaming.
  int m_mode, m_rst_seen, m_slot, m_ramp_src, m_p0, m_p1, m_r;
  int e_dat, e_sel, e_wrt, e_rdy, e_rst;

  // Signed sample (held mod 2^14) to DAC code: code = 8191 - s, wrapped to 14 bits.
  function automatic int code_of(input int v);
    return (8191 - v) & 16383;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit took;
    took = (e_rdy != 0) && dac_valid;
    if (!adc_rstn) begin
      m_mode = 0; m_rst_seen = 0; m_slot = 0; m_ramp_src = 0;
      m_p0 = 0; m_p1 = 0; m_r = 0;
    end else if (m_mode == 0) begin
      if (m_rst_seen == RSTC) m_mode = 1;
      else m_rst_seen++;
    end else if (m_mode == 1) begin
      if (enable) begin
        m_mode = 2; m_slot = 0; m_ramp_src = int'(test_mode);
      end
    end else begin
      if (m_slot == 1) begin
        if (took) begin
          m_p0 = int'(dac0_in); m_p1 = int'(dac1_in);
        end
        if (m_ramp_src != 0) m_r = (m_r + 1) % 16384;
      end
      if (!enable) begin
        m_mode = 1; m_slot = 0; m_p0 = 0; m_p1 = 0;
      end else if (m_slot == 1) begin
        m_slot = 0; m_ramp_src = int'(test_mode);
      end else begin
        m_slot = 1;
      end
    end
    // Expected outputs for the cycle just entered.
    e_rst = (m_mode == 0) ? 1 : 0;
    e_dat = 16'h1FFF; e_sel = 0; e_wrt = 0; e_rdy = 0;
    if (m_mode == 2) begin
      if (m_ramp_src != 0) e_dat = code_of(m_slot == 1 ? 16383 - m_r : m_r);
      else                 e_dat = code_of(m_slot == 1 ? m_p1 : m_p0);
      e_sel = m_slot;
      e_wrt = m_slot;
      e_rdy = (m_slot == 1 && m_ramp_src == 0 && !test_mode) ? 1 : 0;
    end
  endtask

  // Drive inputs, run one clock, compare every output against the model.
  task automatic tick(input bit rstn, input bit en, input bit tm, input bit vld,
                      input int d0, input int d1);
    adc_rstn  = rstn;
    enable    = en;
    test_mode = tm;
    dac_valid = vld;
    dac0_in   = W'(d0 & 16383);
    dac1_in   = W'(d1 & 16383);
    model_step();
    @(negedge adc_clk);
    check("dac_rst", int'(dac_rst), e_rst);
    check("dac_dat", int'(dac_dat), e_dat);
    check("dac_sel", int'(dac_sel), e_sel);
    check("dac_wrt", int'(dac_wrt), e_wrt);
    check("dac_ready", int'(dac_ready), e_rdy);
  endtask

  // Release reset and measure how long dac_rst stays high (bounded).
  task automatic release_and_count(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1, 0, 0, 0, 0, 0);
      if (dac_rst) n++;
      else break;
    end
    check(name, n, RSTC);
  endtask

  typedef struct {
    int s0;
    int s1;
    int c0;
    int c1;
  } vec_t;

  vec_t vecs[5];

  initial begin
    bit en_r, tm_r, rn;

    vecs[0] = '{0,     0,     'h1FFF, 'h1FFF};
    vecs[1] = '{8191,  -8192, 'h0000, 'h3FFF};
    vecs[2] = '{-1,    1,     'h2000, 'h1FFE};
    vecs[3] = '{-8192, 8191,  'h3FFF, 'h0000};
    vecs[4] = '{100,   -100,  'h1F9B, 'h2063};

    // Reset sequence: 5 cycles low, then exactly RSTC cycles of dac_rst.
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      check("reset_dat", int'(dac_dat), 'h1FFF);
    end
    release_and_count("rst_len");

    // Streaming through the conversion table, valid held high.
    tick(1, 1, 0, 1, vecs[0].s0, vecs[0].s1);
    check("run_first_sel", int'(dac_sel), 0);
    tick(1, 1, 0, 1, vecs[0].s0, vecs[0].s1);
    check("run_first_rdy", int'(dac_ready), 1);
    foreach (vecs[i]) begin
      tick(1, 1, 0, 1, vecs[i].s0, vecs[i].s1);
      check("vec_c0", int'(dac_dat), vecs[i].c0);
      check("vec_sel0", int'(dac_sel), 0);
      tick(1, 1, 0, 1, vecs[i].s0, vecs[i].s1);
      check("vec_c1", int'(dac_dat), vecs[i].c1);
      check("vec_wrt1", int'(dac_wrt), 1);
    end

    // Hold: no new valid, last pair (100,-100) repeats with write strobes.
    for (int k = 0; k < 10; k++) begin
      tick(1, 1, 0, 0, 0, 0);
      check("hold_dat", int'(dac_dat), (k % 2 == 0) ? 'h1F9B : 'h2063);
    end

    // Enable drop, then re-enable shows the cleared (0,0) pair.
    tick(1, 0, 0, 1, 5, 5);
    check("drop_dat", int'(dac_dat), 'h1FFF);
    check("drop_wrt", int'(dac_wrt), 0);
    check("drop_rdy", int'(dac_ready), 0);
    tick(1, 1, 0, 1, 5, 5);
    check("reen_c0", int'(dac_dat), 'h1FFF);
    tick(1, 1, 0, 1, 5, 5);
    check("reen_c1", int'(dac_dat), 'h1FFF);
    tick(1, 1, 0, 1, 5, 5);
    check("reen_acc", int'(dac_dat), code_of(5));
    // Enable falls on an accept cycle: pair is dropped on entry to idle.
    tick(1, 1, 0, 1, 77, 77);
    tick(1, 0, 0, 1, 77, 77);
    tick(1, 1, 0, 0, 0, 0);
    check("accdrop_c0", int'(dac_dat), 'h1FFF);

    // Randomized traffic against the model.
    en_r = 1; tm_r = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(23) == 0) en_r = ~en_r;
      if ($urandom_range(63) == 0) tm_r = ~tm_r;
      rn = ($urandom_range(999) != 0);
      tick(rn, en_r, tm_r, 1'($urandom_range(1)),
           int'($urandom_range(16383)), int'($urandom_range(16383)));
    end

    // Reset asserted mid-run restarts the full converter reset sequence.
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 1, 0, 1, 9, 9);
    tick(0, 1, 0, 1, 9, 9);
    check("midrst_rst", int'(dac_rst), 1);
    check("midrst_dat", int'(dac_dat), 'h1FFF);
    release_and_count("midrst_len");

    // Test ramp from idle with r = 0; runs a full wrap of 16384 pairs.
    tick(1, 1, 1, 1, 1, 1);
    check("ramp0_c0", int'(dac_dat), 'h1FFF);
    tick(1, 1, 1, 1, 1, 1);
    check("ramp0_c1", int'(dac_dat), 'h2000);
    for (int k = 1; k < 16384; k++) begin
      tick(1, 1, 1, 1, 1, 1);
      if (k == 1) check("ramp1_c0", int'(dac_dat), 'h1FFE);
      tick(1, 1, 1, 1, 1, 1);
    end
    tick(1, 1, 1, 1, 1, 1);
    check("ramp_wrap_c0", int'(dac_dat), 'h1FFF);
    tick(1, 1, 1, 1, 1, 1);
    check("ramp_wrap_c1", int'(dac_dat), 'h2000);
    check("ramp_rdy", int'(dac_ready), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
